tdm_demux_1to2: RTL

Receive-side counterpart of the 2:1 display-code mux. A single 7-bit bus carries frames of two words in time-division order: channel 1, then channel 2. This block realigns to the frame marker, captures both words, and presents them together on two held parallel outputs. It sits between the shared serialised segment bus and the two display-driver inputs, and flags framing errors and stalls.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_timeout_counter.sv | 41 ++++
 rtl/tdm_demux_1to2.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM display-code link (transmit mux and receive demux).
// Holds the frame FSM encoding and the default word, timeout and blank-code constants.
package tdm_pkg;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_WAIT2 = 1'b1
    } tdm_state_e;

    localparam int          DEF_WIDTH   = 7;
    localparam int          DEF_TIMEOUT = 255;
    localparam logic [6:0]  BLANK_CODE  = 7'h7F;  // all segments off, active-low

endpackage

// File: rtl/tdm_timeout_counter.sv
// Saturating idle timer for the gap between channel-1 and channel-2 words.
// It flags expiry once TIMEOUT-1 idle cycles have been counted and never wraps.
module tdm_timeout_counter
    import tdm_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign expired = (timer_q == LAST);

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable && !expired) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/tdm_demux_1to2.sv
// Receive-side 1:2 TDM demux: realigns on the frame marker, pairs channel-1/channel-2
// words and presents them together on held outputs, flagging framing errors and stalls.
module tdm_demux_1to2
    import tdm_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               TIMEOUT   = DEF_TIMEOUT,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(BLANK_CODE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out_valid,
    output logic             sync_err,
    output logic             locked
);

    tdm_state_e       state_q,     state_d;
    logic [WIDTH-1:0] shadow_q,    shadow_d;
    logic [WIDTH-1:0] out1_q,      out1_d;
    logic [WIDTH-1:0] out2_q,      out2_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q,  sync_err_d;
    logic             locked_q,    locked_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    tdm_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        locked_d    = locked_q;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (din_valid) begin
                    if (din_sof) begin
                        shadow_d  = din;
                        tmr_clear = 1'b1;
                        state_d   = ST_WAIT2;
                    end else begin
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                    end
                end
            end
            ST_WAIT2: begin
                if (din_valid) begin
                    if (din_sof) begin
                        // Restart: the new marker word becomes the pending channel-1 word.
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        shadow_d   = din;
                        tmr_clear  = 1'b1;
                    end else begin
                        out1_d      = shadow_q;
                        out2_d      = din;
                        out_valid_d = 1'b1;
                        locked_d    = 1'b1;
                        state_d     = ST_HUNT;
                    end
                end else if (tmr_expired) begin
                    sync_err_d = 1'b1;
                    locked_d   = 1'b0;
                    shadow_d   = '0;
                    state_d    = ST_HUNT;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            shadow_q    <= '0;
            out1_q      <= RESET_VAL;
            out2_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            locked_q    <= locked_d;
        end
    end

    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign locked    = locked_q;

endmodule
